// File: rtl/rvfi_pkg.sv
// rtl/rvfi_pkg.sv - shared types, marker/halt constants and halt decode for the RVFI commit tracker
package rvfi_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } commit_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SEG    = 2'd2,
    ST_HALTED = 2'd3
  } tracker_state_e;

  localparam logic [31:0] SEG_START_INST = 32'h0010_2013;
  localparam logic [31:0] SEG_STOP_INST  = 32'h0020_2013;

  localparam logic [31:0] HALT_BRANCH_INST = 32'h0000_0063;
  localparam logic [31:0] HALT_JUMP_INST   = 32'h0000_006f;
  localparam logic [31:0] HALT_SLTI_INST   = 32'hF000_2013;

  // A self-loop (pc_wdata == pc_rdata) is treated as the program parking itself.
  function automatic logic is_halt(input commit_rec_t rec);
    return (rec.pc_rdata == rec.pc_wdata) ||
           (rec.inst == HALT_BRANCH_INST) ||
           (rec.inst == HALT_JUMP_INST) ||
           (rec.inst == HALT_SLTI_INST);
  endfunction

endpackage

// File: rtl/rvfi_canon.sv
// rtl/rvfi_canon.sv - combinational canonicalisation of a commit record before the output register
module rvfi_canon
  import rvfi_pkg::*;
(
  input  commit_rec_t rec_i,
  output commit_rec_t rec_o
);

  always_comb begin
    rec_o = rec_i;
    if (rec_i.rs1_addr == 5'd0) rec_o.rs1_rdata = '0;
    if (rec_i.rs2_addr == 5'd0) rec_o.rs2_rdata = '0;
    if (rec_i.rd_addr == 5'd0)  rec_o.rd_wdata  = '0;
    rec_o.mem_addr[1:0] = 2'b00;
    for (int b = 0; b < 4; b++) begin
      if (!rec_i.mem_rmask[b]) rec_o.mem_rdata[8*b +: 8] = 8'h00;
      if (!rec_i.mem_wmask[b]) rec_o.mem_wdata[8*b +: 8] = 8'h00;
    end
  end

endmodule

// File: rtl/rvfi_commit_tracker.sv
// rtl/rvfi_commit_tracker.sv - registered RVFI commit stream with order, halt, segment counters; RVFI_PC_CHECK_EN adds PC continuity check
module rvfi_commit_tracker
  import rvfi_pkg::*;
#(
  parameter int ORDER_W = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wb_valid_i,
  input  commit_rec_t        wb_rec_i,
  output logic               mon_valid_o,
  output logic [ORDER_W-1:0] mon_order_o,
  output commit_rec_t        mon_rec_o,
  output logic               mon_halt_o,
  output logic               seg_active_o,
  output logic [ORDER_W-1:0] seg_insts_o,
  output logic [ORDER_W-1:0] seg_cycles_o,
  output logic               pc_err_o
);

  tracker_state_e     state_q, state_d;
  logic [ORDER_W-1:0] order_q, order_d;
  logic [ORDER_W-1:0] seg_insts_q, seg_insts_d;
  logic [ORDER_W-1:0] seg_cycles_q, seg_cycles_d;
  logic               mon_valid_q;
  logic [ORDER_W-1:0] mon_order_q;
  commit_rec_t        mon_rec_q;
  commit_rec_t        canon_rec;
  logic               emit, halt, start, stop;

  rvfi_canon u_canon (
    .rec_i (wb_rec_i),
    .rec_o (canon_rec)
  );

  always_comb begin
    emit  = wb_valid_i && (state_q != ST_HALTED);
    halt  = emit && is_halt(wb_rec_i);
    start = emit && !halt && (wb_rec_i.inst == SEG_START_INST);
    stop  = emit && !halt && (state_q == ST_SEG) && (wb_rec_i.inst == SEG_STOP_INST);

    state_d = state_q;
    if (halt)                             state_d = ST_HALTED;
    else if (start)                       state_d = ST_SEG;
    else if (stop)                        state_d = ST_RUN;
    else if (emit && state_q == ST_IDLE)  state_d = ST_RUN;

    order_d = emit ? order_q + ORDER_W'(1) : order_q;

    // The stop/halting commit's own cycle is still counted; leaving SEG freezes both.
    seg_insts_d  = seg_insts_q;
    seg_cycles_d = seg_cycles_q;
    if (start) begin
      seg_insts_d  = '0;
      seg_cycles_d = '0;
    end else if (state_q == ST_SEG) begin
      seg_cycles_d = seg_cycles_q + ORDER_W'(1);
      if (emit) seg_insts_d = seg_insts_q + ORDER_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      order_q      <= '0;
      seg_insts_q  <= '0;
      seg_cycles_q <= '0;
      mon_valid_q  <= 1'b0;
      mon_order_q  <= '0;
      mon_rec_q    <= '0;
    end else begin
      state_q      <= state_d;
      order_q      <= order_d;
      seg_insts_q  <= seg_insts_d;
      seg_cycles_q <= seg_cycles_d;
      mon_valid_q  <= emit;
      if (emit) begin
        mon_order_q <= order_q;
        mon_rec_q   <= canon_rec;
      end
    end
  end

`ifdef RVFI_PC_CHECK_EN
  logic [31:0] exp_pc_q;
  logic        exp_pc_vld_q;
  logic        pc_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_pc_q     <= '0;
      exp_pc_vld_q <= 1'b0;
      pc_err_q     <= 1'b0;
    end else if (emit) begin
      exp_pc_q     <= wb_rec_i.pc_wdata;
      exp_pc_vld_q <= 1'b1;
      if (exp_pc_vld_q && (wb_rec_i.pc_rdata != exp_pc_q)) pc_err_q <= 1'b1;
    end
  end

  assign pc_err_o = pc_err_q;
`else
  assign pc_err_o = 1'b0;
`endif

  assign mon_valid_o  = mon_valid_q;
  assign mon_order_o  = mon_order_q;
  assign mon_rec_o    = mon_rec_q;
  assign mon_halt_o   = (state_q == ST_HALTED);
  assign seg_active_o = (state_q == ST_SEG);
  assign seg_insts_o  = seg_insts_q;
  assign seg_cycles_o = seg_cycles_q;

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// tb/tb_rvfi_commit_tracker.sv - randomized and directed self-checking bench for rvfi_commit_tracker
module tb_rvfi_commit_tracker;
  import rvfi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  commit_rec_t wb_rec = '0;
  logic        mon_valid;
  logic [63:0] mon_order;
  commit_rec_t mon_rec;
  logic        mon_halt, seg_active, pc_err;
  logic [63:0] seg_insts, seg_cycles;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  rvfi_commit_tracker #(.ORDER_W(64)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wb_valid_i   (wb_valid),
    .wb_rec_i     (wb_rec),
    .mon_valid_o  (mon_valid),
    .mon_order_o  (mon_order),
    .mon_rec_o    (mon_rec),
    .mon_halt_o   (mon_halt),
    .seg_active_o (seg_active),
    .seg_insts_o  (seg_insts),
    .seg_cycles_o (seg_cycles),
    .pc_err_o     (pc_err)
  );

  always #5 clk = ~clk;

  // Reference model state: what the monitor outputs must show after each edge.
  bit          m_valid, m_halt, m_seg, m_pcerr, m_exp_vld;
  logic [63:0] m_order, m_next, m_insts, m_cycles;
  logic [31:0] m_exp_pc, cur_pc;
  commit_rec_t m_rec;

  function automatic commit_rec_t canon(input commit_rec_t r);
    commit_rec_t c = r;
    logic [31:0] rm, wm;
    rm = {{8{r.mem_rmask[3]}}, {8{r.mem_rmask[2]}}, {8{r.mem_rmask[1]}}, {8{r.mem_rmask[0]}}};
    wm = {{8{r.mem_wmask[3]}}, {8{r.mem_wmask[2]}}, {8{r.mem_wmask[1]}}, {8{r.mem_wmask[0]}}};
    c.mem_rdata = r.mem_rdata & rm;
    c.mem_wdata = r.mem_wdata & wm;
    c.mem_addr  = r.mem_addr & 32'hFFFF_FFFC;
    c.rs1_rdata = (r.rs1_addr == 5'd0) ? 32'd0 : r.rs1_rdata;
    c.rs2_rdata = (r.rs2_addr == 5'd0) ? 32'd0 : r.rs2_rdata;
    c.rd_wdata  = (r.rd_addr  == 5'd0) ? 32'd0 : r.rd_wdata;
    return c;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_halt = 0; m_seg = 0; m_pcerr = 0; m_exp_vld = 0;
    m_order = 0; m_next = 0; m_insts = 0; m_cycles = 0; m_exp_pc = 0; m_rec = '0;
  endtask

  task automatic model_step();
    bit was_seg, h;
    was_seg = m_seg;
    m_valid = 0;
    if (was_seg) m_cycles = m_cycles + 1;
    if (wb_valid && !m_halt) begin
      h = (wb_rec.pc_rdata == wb_rec.pc_wdata) || (wb_rec.inst == 32'h63) ||
          (wb_rec.inst == 32'h6f) || (wb_rec.inst == 32'hF0002013);
      m_valid = 1;
      m_order = m_next;
      m_next  = m_next + 1;
      m_rec   = canon(wb_rec);
      if (was_seg) m_insts = m_insts + 1;
`ifdef RVFI_PC_CHECK_EN
      if (m_exp_vld && wb_rec.pc_rdata != m_exp_pc) m_pcerr = 1;
      m_exp_pc  = wb_rec.pc_wdata;
      m_exp_vld = 1;
`endif
      if (h) begin
        m_halt = 1;
        m_seg  = 0;
      end else if (wb_rec.inst == 32'h00102013) begin
        m_seg = 1; m_insts = 0; m_cycles = 0;
      end else if (wb_rec.inst == 32'h00202013) begin
        m_seg = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mon_valid", 64'(mon_valid), 64'(m_valid));
      chk("mon_order", mon_order, m_order);
      chk("mon_halt", 64'(mon_halt), 64'(m_halt));
      chk("seg_active", 64'(seg_active), 64'(m_seg));
      chk("seg_insts", seg_insts, m_insts);
      chk("seg_cycles", seg_cycles, m_cycles);
      chk("pc_err", 64'(pc_err), 64'(m_pcerr));
      total++;
      if (mon_rec !== m_rec) begin
        bad++;
        $display("FAIL mon_rec: got %h want %h", mon_rec, m_rec);
      end
    end
  end

  task automatic cyc(input bit v, input commit_rec_t r);
    wb_valid = v;
    wb_rec   = r;
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wb_valid = 1'b0;
    model_reset();
    cyc(0, '0);
    cyc(0, '0);
    rst = 1'b0;
    cur_pc = 32'h100;
  endtask

  function automatic commit_rec_t mk(input logic [31:0] inst, input logic [31:0] pc);
    commit_rec_t r = '0;
    r.inst     = inst;
    r.pc_rdata = pc;
    r.pc_wdata = pc + 32'd4;
    return r;
  endfunction

  task automatic commit(input logic [31:0] inst);
    cyc(1, mk(inst, cur_pc));
    cur_pc = cur_pc + 32'd4;
  endtask

  function automatic commit_rec_t rnd_rec(input logic [31:0] pc);
    commit_rec_t r;
    int k;
    r.inst      = $urandom;
    r.pc_rdata  = ($urandom_range(0, 15) == 0) ? $urandom : pc;
    r.pc_wdata  = r.pc_rdata + 32'd4;
    r.rs1_addr  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
    r.rs2_addr  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
    r.rd_addr   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
    r.rs1_rdata = $urandom;
    r.rs2_rdata = $urandom;
    r.rd_wdata  = $urandom;
    r.mem_addr  = $urandom;
    r.mem_rmask = 4'($urandom);
    r.mem_wmask = 4'($urandom);
    r.mem_rdata = $urandom;
    r.mem_wdata = $urandom;
    k = $urandom_range(0, 99);
    if (k < 10)      r.inst = 32'h00102013;
    else if (k < 20) r.inst = 32'h00202013;
    else if (k < 21) r.inst = 32'h00000063;
    else if (k < 22) r.inst = 32'h0000006f;
    else if (k < 23) r.inst = 32'hF0002013;
    else if (k < 24) r.pc_wdata = r.pc_rdata;
    return r;
  endfunction

  initial begin
    commit_rec_t r;
    bit exp_err;
    model_reset();
    chk_en = 1'b1;
    do_reset();
    chk("reset mon_valid", 64'(mon_valid), 64'd0);
    chk("reset mon_order", mon_order, 64'd0);
    chk("reset seg_insts", seg_insts, 64'd0);

    // Five addi to x0: order 0..4 back to back, rd data canonicalised to 0.
    for (int i = 0; i < 5; i++) begin
      r = mk(32'h0000_0013, cur_pc);
      r.rd_wdata = 32'hDEAD;
      cyc(1, r);
      cur_pc = cur_pc + 32'd4;
      chk("addi order", mon_order, 64'(i));
      chk("addi valid", 64'(mon_valid), 64'd1);
      chk("addi rd_wdata", 64'(mon_rec.rd_wdata), 64'd0);
    end
    cyc(0, '0);

    // Halt on a branch-to-self opcode at order 3, later commits dropped.
    do_reset();
    for (int i = 0; i < 3; i++) commit(32'h0000_0013);
    commit(32'h0000_0063);
    chk("halt flag", 64'(mon_halt), 64'd1);
    chk("halt order", mon_order, 64'd3);
    chk("halt valid", 64'(mon_valid), 64'd1);
    commit(32'h0000_0013);
    chk("post-halt valid", 64'(mon_valid), 64'd0);
    commit(32'h0000_0013);
    chk("post-halt order", mon_order, 64'd3);

    // Segment: start, 4 commits, 2 idle, stop.
    do_reset();
    commit(32'h0000_0013);
    commit(32'h0010_2013);
    chk("seg start active", 64'(seg_active), 64'd1);
    for (int i = 0; i < 4; i++) commit(32'h0000_0013);
    cyc(0, '0);
    cyc(0, '0);
    commit(32'h0020_2013);
    chk("seg insts", seg_insts, 64'd5);
    chk("seg cycles", seg_cycles, 64'd7);
    chk("seg stopped", 64'(seg_active), 64'd0);

    // Store canonicalisation.
    r = mk(32'h0000_0023, cur_pc);
    r.mem_addr = 32'h1003; r.mem_wmask = 4'b1000; r.mem_wdata = 32'h1122_3344;
    cyc(1, r);
    cur_pc = cur_pc + 32'd4;
    chk("store addr", 64'(mon_rec.mem_addr), 64'h1000);
    chk("store wdata", 64'(mon_rec.mem_wdata), 64'h1100_0000);

    // Back-to-back start/stop.
    commit(32'h0010_2013);
    commit(32'h0020_2013);
    chk("b2b insts", seg_insts, 64'd1);
    chk("b2b cycles", seg_cycles, 64'd1);

    // PC discontinuity 0x100 -> 0x104 expected, 0x108 seen.
`ifdef RVFI_PC_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    cyc(1, mk(32'h0000_0013, 32'h100));
    chk("pc ok", 64'(pc_err), 64'd0);
    cyc(1, mk(32'h0000_0013, 32'h108));
    chk("pc err", 64'(pc_err), 64'(exp_err));
    cyc(1, mk(32'h0000_0013, 32'h10C));
    chk("pc err sticky", 64'(pc_err), 64'(exp_err));

    // Reset in the cycle after order 7.
    do_reset();
    for (int i = 0; i < 8; i++) commit(32'h0000_0013);
    chk("pre-reset order", mon_order, 64'd7);
    do_reset();
    commit(32'h0000_0013);
    chk("post-reset order", mon_order, 64'd0);
    chk("post-reset halt", 64'(mon_halt), 64'd0);

    // Randomized rounds.
    for (int round = 0; round < 8; round++) begin
      do_reset();
      for (int c = 0; c < 120; c++) begin
        if ($urandom_range(0, 3) != 0) begin
          r = rnd_rec(cur_pc);
          cyc(1, r);
          cur_pc = r.pc_wdata;
        end else begin
          cyc(0, rnd_rec(cur_pc));
        end
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
